// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo
// -------------------------------------------------------------------------
// 8N1 serial receiver with a small show-ahead receive FIFO and sticky error
// flags. It sits between the asynchronous rxd pin and a bus register.
//
// Parameters
//   DIV    clock cycles per bit (>= 4)
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports
//   clk          system clock, rising edge
//   resetb       asynchronous active-low reset
//   rxd          serial line, asynchronous, idle high
//   rd           one-cycle pop strobe
//   clrerr       clears ferr and ovr (a simultaneous set event wins)
//   dout         FIFO head byte, valid while rxrdy = 1
//   rxrdy        FIFO not empty
//   ferr         sticky framing error
//   ovr          sticky overrun
//   busy         receiver FSM is not idle
//   dbg_state_o  receiver FSM state encoding, for observation only
//
// Read handshake: rxrdy acts as "valid" and rd as "ready". A byte is popped
// only on a cycle with rd = 1 and rxrdy = 1; rd while rxrdy = 0 is ignored.
// dout and rxrdy reflect the pop on the following cycle.
// -------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DIV   = 217,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clrerr,
    output logic [7:0] dout,
    output logic       rxrdy,
    output logic       ferr,
    output logic       ovr,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam int CW = $clog2(DIV);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [NW-1:0] FULL_N  = NW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_e;

    // ---------------------------------------------------------------------
    // Input synchroniser (reset to the idle level so no false start)
    // ---------------------------------------------------------------------
    logic sync1_q;
    logic rxs_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
        end
    end

    // ---------------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          push;
    logic          ferr_set;
    logic          expire;

    assign expire = (cnt_q == '0);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        // Free-running down counter; parks at zero when nothing reloads it.
        cnt_d    = expire ? cnt_q : cnt_q - CW'(1);
        idx_d    = idx_q;
        sh_d     = sh_q;
        push     = 1'b0;
        ferr_set = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expire) begin
                    if (!rxs_q) begin
                        cnt_d   = FULL_M1;
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    // LSB first: each new bit enters at the top.
                    sh_d  = {rxs_q, sh_q[7:1]};
                    cnt_d = FULL_M1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (expire) begin
                    if (rxs_q) begin
                        // Re-arm at mid-stop so back-to-back frames work.
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // Hold here while the line stays low so a break is not
                // decoded as a string of 0x00 frames.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

    // ---------------------------------------------------------------------
    // Show-ahead FIFO
    // ---------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrptr_q, wrptr_d;
    logic [AW-1:0] rdptr_q, rdptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          fifo_full;
    logic          pop;
    logic          wr_en;
    logic          ovr_set;

    assign fifo_full = (count_q == FULL_N);
    assign pop       = rd && (count_q != '0);
    // A push into a full FIFO is still accepted when a pop frees a slot in
    // the same cycle.
    assign wr_en     = push && (!fifo_full || pop);
    assign ovr_set   = push && fifo_full && !pop;

    always_comb begin
        wrptr_d = wr_en ? wrptr_q + AW'(1) : wrptr_q;
        rdptr_d = pop   ? rdptr_q + AW'(1) : rdptr_q;
        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            count_q <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            count_q <= count_d;
        end
    end

    // Storage is intentionally not reset; dout is only meaningful with rxrdy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wrptr_q] <= sh_q;
        end
    end

    assign dout  = mem[rdptr_q];
    assign rxrdy = (count_q != '0);

    // ---------------------------------------------------------------------
    // Sticky error flags: set beats clear in the same cycle
    // ---------------------------------------------------------------------
    logic ferr_q, ferr_d;
    logic ovr_q, ovr_d;

    always_comb begin
        ferr_d = ferr_set ? 1'b1 : (clrerr ? 1'b0 : ferr_q);
        ovr_d  = ovr_set  ? 1'b1 : (clrerr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    assign ferr = ferr_q;
    assign ovr  = ovr_q;

endmodule
